// File: rtl/calc_pkg.sv
// Shared calculator definitions: key codes, keypad map, scan FSM states, operand width.
package calc_pkg;

    localparam int unsigned OPERAND_W = 8;
    localparam int unsigned KEY_W     = 4;

    localparam logic [KEY_W-1:0] KEY_MAX_DIGIT = 4'd9;
    localparam logic [KEY_W-1:0] KEY_CLR       = 4'd13;
    localparam logic [KEY_W-1:0] KEY_BKSP      = 4'd14;

    typedef enum logic [1:0] {
        ST_SCAN       = 2'd0,
        ST_PRESS_DB   = 2'd1,
        ST_HELD       = 2'd2,
        ST_RELEASE_DB = 2'd3
    } kp_state_e;

    // Index of the lowest active-low line; serves both row priority and column decode.
    function automatic logic [1:0] low_index(input logic [3:0] lines);
        if (!lines[0]) begin
            return 2'd0;
        end else if (!lines[1]) begin
            return 2'd1;
        end else if (!lines[2]) begin
            return 2'd2;
        end else begin
            return 2'd3;
        end
    endfunction

    // Keypad layout, row-major: 1 2 3 A / 4 5 6 B / 7 8 9 C / CLR 0 BKSP F.
    function automatic logic [KEY_W-1:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        case ({row, col})
            4'h0:    return 4'd1;
            4'h1:    return 4'd2;
            4'h2:    return 4'd3;
            4'h3:    return 4'd10;
            4'h4:    return 4'd4;
            4'h5:    return 4'd5;
            4'h6:    return 4'd6;
            4'h7:    return 4'd11;
            4'h8:    return 4'd7;
            4'h9:    return 4'd8;
            4'hA:    return 4'd9;
            4'hB:    return 4'd12;
            4'hC:    return KEY_CLR;
            4'hD:    return 4'd0;
            4'hE:    return KEY_BKSP;
            default: return 4'd15;
        endcase
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Stable-condition counter: asserts done on the COUNT-th consecutive stable cycle while enabled,
// restarting from zero whenever the condition drops.
module keypad_debounce #(
    parameter int unsigned COUNT = 20000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_stable,
    output logic o_done_c,
    output logic o_broken_c
);

    localparam int unsigned CW = (COUNT > 1) ? $clog2(COUNT) : 1;

    logic [CW-1:0] r_cnt;

    assign o_done_c   = i_en && i_stable && (r_cnt == CW'(COUNT - 1));
    assign o_broken_c = i_en && !i_stable;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (!i_en || !i_stable || o_done_c) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/keypad_entry.sv
// Keypad column scanner with press/release debounce and a 3-digit decimal operand accumulator.
// Define KEYPAD_BACKSPACE_EN to make key 14 drop the last entered digit.
module keypad_entry
    import calc_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned DEBOUNCE_CNT = 20000
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic [3:0]           Rows,
    input  logic                 entry_clr,
    output logic [3:0]           COL,
    output logic                 key_valid,
    output logic [KEY_W-1:0]     key_code,
    output logic [OPERAND_W-1:0] value,
    output logic [1:0]           ndigits
);

    localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned AW = 12;

    kp_state_e             r_state;
    kp_state_e             w_state_nxt;
    logic [DW-1:0]         r_dwell;
    logic [DW-1:0]         w_dwell_nxt;
    logic [3:0]            r_col;
    logic [3:0]            w_col_nxt;
    logic [3:0]            r_rows_cap;
    logic [3:0]            w_rows_cap_nxt;
    logic                  r_key_valid;
    logic                  w_key_valid_nxt;
    logic [KEY_W-1:0]      r_key_code;
    logic [KEY_W-1:0]      w_key_code_nxt;
    logic [OPERAND_W-1:0]  r_value;
    logic [1:0]            r_ndigits;

    logic                  w_dwell_end;
    logic                  w_rows_idle;
    logic [3:0]            w_col_rot;
    logic [KEY_W-1:0]      w_key_sel;
    logic                  w_press_done;
    logic                  w_press_broken;
    logic                  w_rel_done;
    logic                  w_rel_broken;
    logic [AW-1:0]         w_shifted;
    logic                  w_digit_ok;

    assign w_dwell_end = (r_dwell == DW'(SCAN_DIV - 1));
    assign w_rows_idle = &Rows;
    assign w_col_rot   = {r_col[2:0], r_col[3]};
    assign w_key_sel   = key_lookup(low_index(r_rows_cap), low_index(r_col));

    keypad_debounce #(.COUNT(DEBOUNCE_CNT)) u_press_db (
        .i_clk      (clock),
        .i_rst_n    (clear),
        .i_en       (r_state == ST_PRESS_DB),
        .i_stable   (Rows == r_rows_cap),
        .o_done_c   (w_press_done),
        .o_broken_c (w_press_broken)
    );

    keypad_debounce #(.COUNT(DEBOUNCE_CNT)) u_release_db (
        .i_clk      (clock),
        .i_rst_n    (clear),
        .i_en       (r_state == ST_RELEASE_DB),
        .i_stable   (w_rows_idle),
        .o_done_c   (w_rel_done),
        .o_broken_c (w_rel_broken)
    );

    always_ff @(posedge clock) begin
        if (!clear) begin
            r_state <= ST_SCAN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_SCAN: begin
                if (w_dwell_end && !w_rows_idle) begin
                    w_state_nxt = ST_PRESS_DB;
                end
            end
            ST_PRESS_DB: begin
                if (w_press_broken) begin
                    w_state_nxt = ST_SCAN;
                end else if (w_press_done) begin
                    w_state_nxt = ST_HELD;
                end
            end
            ST_HELD: begin
                if (w_rows_idle) begin
                    w_state_nxt = ST_RELEASE_DB;
                end
            end
            ST_RELEASE_DB: begin
                if (w_rel_broken) begin
                    w_state_nxt = ST_HELD;
                end else if (w_rel_done) begin
                    w_state_nxt = ST_SCAN;
                end
            end
            default: w_state_nxt = ST_SCAN;
        endcase
    end

    // Dwell only runs in SCAN, so any return to SCAN restarts the column dwell.
    always_comb begin
        w_dwell_nxt     = '0;
        w_col_nxt       = r_col;
        w_rows_cap_nxt  = r_rows_cap;
        w_key_valid_nxt = 1'b0;
        w_key_code_nxt  = r_key_code;
        case (r_state)
            ST_SCAN: begin
                w_dwell_nxt = w_dwell_end ? '0 : r_dwell + DW'(1);
                if (w_dwell_end) begin
                    if (w_rows_idle) begin
                        w_col_nxt = w_col_rot;
                    end else begin
                        w_rows_cap_nxt = Rows;
                    end
                end
            end
            ST_PRESS_DB: begin
                if (w_press_done) begin
                    w_key_valid_nxt = 1'b1;
                    w_key_code_nxt  = w_key_sel;
                end
            end
            ST_RELEASE_DB: begin
                if (w_rel_done) begin
                    w_col_nxt = w_col_rot;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            r_dwell     <= '0;
            r_col       <= 4'b1110;
            r_rows_cap  <= 4'hF;
            r_key_valid <= 1'b0;
            r_key_code  <= '0;
        end else begin
            r_dwell     <= w_dwell_nxt;
            r_col       <= w_col_nxt;
            r_rows_cap  <= w_rows_cap_nxt;
            r_key_valid <= w_key_valid_nxt;
            r_key_code  <= w_key_code_nxt;
        end
    end

    // Accumulator acts on the registered key pulse, so results appear the cycle after key_valid.
    assign w_shifted  = AW'(r_value) * AW'(10) + AW'(r_key_code);
    assign w_digit_ok = (r_key_code <= KEY_MAX_DIGIT) && (r_ndigits != 2'd3)
                        && (w_shifted <= AW'(2 ** OPERAND_W - 1));

    always_ff @(posedge clock) begin
        if (!clear) begin
            r_value   <= '0;
            r_ndigits <= '0;
        end else if (entry_clr) begin
            r_value   <= '0;
            r_ndigits <= '0;
        end else if (r_key_valid) begin
            if (w_digit_ok) begin
                r_value   <= w_shifted[OPERAND_W-1:0];
                r_ndigits <= r_ndigits + 2'd1;
            end else if (r_key_code == KEY_CLR) begin
                r_value   <= '0;
                r_ndigits <= '0;
            end
`ifdef KEYPAD_BACKSPACE_EN
            else if ((r_key_code == KEY_BKSP) && (r_ndigits != 2'd0)) begin
                r_value   <= r_value / OPERAND_W'(10);
                r_ndigits <= r_ndigits - 2'd1;
            end
`endif
        end
    end

    assign COL       = r_col;
    assign key_valid = r_key_valid;
    assign key_code  = r_key_code;
    assign value     = r_value;
    assign ndigits   = r_ndigits;

endmodule

// File: tb/tb_keypad_entry.sv
// Scoreboard bench for keypad_entry: directed key presses push expected results,
// a monitor checks them on every key_valid pulse.
module tb_keypad_entry;

    localparam int unsigned SCAN_DIV     = 4;
    localparam int unsigned DEBOUNCE_CNT = 8;
    localparam int          HOLD         = 20;
    localparam int          NV           = 24;

`ifdef KEYPAD_BACKSPACE_EN
    localparam logic [7:0] BK_V = 8'd4;
    localparam logic [1:0] BK_N = 2'd1;
    localparam logic [7:0] MR_V = 8'd41;
    localparam logic [1:0] MR_N = 2'd2;
`else
    localparam logic [7:0] BK_V = 8'd42;
    localparam logic [1:0] BK_N = 2'd2;
    localparam logic [7:0] MR_V = 8'd42;
    localparam logic [1:0] MR_N = 2'd2;
`endif

    typedef struct packed {
        logic [3:0] code;
        logic [7:0] value;
        logic [1:0] nd;
    } exp_t;

    typedef struct packed {
        logic [3:0] code;
        logic [3:0] extra;
        logic       clr;
        logic       rst;
        logic       bnc;
        logic [7:0] ev;
        logic [1:0] en;
    } vec_t;

    logic       clock = 1'b0;
    logic       clear;
    logic       entry_clr;
    logic [3:0] Rows;
    logic [3:0] COL;
    logic       key_valid;
    logic [3:0] key_code;
    logic [7:0] value;
    logic [1:0] ndigits;

    logic       key_down;
    logic [3:0] key_rows;
    logic [1:0] key_col;

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];

    logic [3:0] keymap [16] = '{4'd1, 4'd2, 4'd3, 4'd10,
                                4'd4, 4'd5, 4'd6, 4'd11,
                                4'd7, 4'd8, 4'd9, 4'd12,
                                4'd13, 4'd0, 4'd14, 4'd15};
    logic [3:0] colseq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    //            code   extra  clr   rst   bnc   value   nd
    vec_t vecs [NV] = '{
        '{4'd1,  4'd0, 1'b0, 1'b0, 1'b0, 8'd1,   2'd1},
        '{4'd2,  4'd0, 1'b0, 1'b0, 1'b0, 8'd12,  2'd2},
        '{4'd3,  4'd0, 1'b0, 1'b0, 1'b0, 8'd123, 2'd3},
        '{4'd4,  4'd0, 1'b0, 1'b0, 1'b0, 8'd123, 2'd3},
        '{4'd13, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0,   2'd0},
        '{4'd2,  4'd0, 1'b0, 1'b0, 1'b0, 8'd2,   2'd1},
        '{4'd5,  4'd0, 1'b0, 1'b0, 1'b0, 8'd25,  2'd2},
        '{4'd6,  4'd0, 1'b0, 1'b0, 1'b0, 8'd25,  2'd2},
        '{4'd5,  4'd0, 1'b0, 1'b0, 1'b0, 8'd255, 2'd3},
        '{4'd13, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0,   2'd0},
        '{4'd4,  4'd0, 1'b0, 1'b0, 1'b0, 8'd4,   2'd1},
        '{4'd7,  4'd0, 1'b1, 1'b0, 1'b0, 8'd0,   2'd0},
        '{4'd8,  4'd0, 1'b0, 1'b0, 1'b1, 8'd0,   2'd0},
        '{4'd8,  4'd0, 1'b0, 1'b0, 1'b0, 8'd8,   2'd1},
        '{4'd13, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0,   2'd0},
        '{4'd4,  4'd0, 1'b0, 1'b0, 1'b0, 8'd4,   2'd1},
        '{4'd2,  4'd0, 1'b0, 1'b0, 1'b0, 8'd42,  2'd2},
        '{4'd10, 4'd0, 1'b0, 1'b1, 1'b0, 8'd42,  2'd2},
        '{4'd4,  4'd0, 1'b0, 1'b0, 1'b0, 8'd4,   2'd1},
        '{4'd2,  4'd0, 1'b0, 1'b0, 1'b0, 8'd42,  2'd2},
        '{4'd14, 4'd0, 1'b0, 1'b0, 1'b0, BK_V,   BK_N},
        '{4'd1,  4'd4, 1'b0, 1'b0, 1'b0, MR_V,   MR_N},
        '{4'd13, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0,   2'd0},
        '{4'd14, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0,   2'd0}
    };

    // Matrix model: a held key pulls its row low only while its column is driven.
    assign Rows = (key_down && !COL[key_col]) ? key_rows : 4'hF;

    always #5 clock = ~clock;

    keypad_entry #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) dut (
        .clock     (clock),
        .clear     (clear),
        .Rows      (Rows),
        .entry_clr (entry_clr),
        .COL       (COL),
        .key_valid (key_valid),
        .key_code  (key_code),
        .value     (value),
        .ndigits   (ndigits)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic key_pos(input logic [3:0] code, output logic [1:0] r, output logic [1:0] c);
        r = 2'd0;
        c = 2'd0;
        for (int i = 0; i < 16; i++) begin
            if (keymap[i] == code) begin
                r = 2'(i / 4);
                c = 2'(i % 4);
            end
        end
    endtask

    // Return on the first cycle of the target column's dwell.
    task automatic wait_col_start(input logic [1:0] c);
        logic [3:0] target;
        int n;
        target = ~(4'b0001 << c);
        n = 0;
        while (COL == target && n < 64) begin
            @(negedge clock);
            n++;
        end
        while (COL != target && n < 64) begin
            @(negedge clock);
            n++;
        end
        if (n >= 64) begin
            total++;
            bad++;
            $display("FAIL col_sync: COL %b never reached %b", COL, target);
        end
    endtask

    task automatic press(input vec_t v);
        logic [1:0] r;
        logic [1:0] c;
        bit clr_done;
        key_pos(v.code, r, c);
        sb_q.push_back({v.code, v.ev, v.en});
        wait_col_start(c);
        key_col  = c;
        key_rows = ~((4'b0001 << r) | v.extra);
        key_down = 1'b1;
        clr_done = 1'b0;
        for (int i = 1; i <= HOLD; i++) begin
            @(negedge clock);
            entry_clr = 1'b0;
            if (v.clr && !clr_done && key_valid) begin
                entry_clr = 1'b1;
                clr_done  = 1'b1;
            end
            if (v.rst && i == 16) clear = 1'b0;
            if (v.rst && i == 17) begin
                check("rst_held_COL", COL, 4'b1110);
                check("rst_held_key_valid", key_valid, 0);
                check("rst_held_key_code", key_code, 0);
                check("rst_held_value", value, 0);
                check("rst_held_ndigits", ndigits, 0);
            end
            if (v.rst && i == 18) clear = 1'b1;
        end
        key_down  = 1'b0;
        entry_clr = 1'b0;
        repeat (12) @(negedge clock);
    endtask

    // Key drops after 3 press-debounce cycles; scanning must resume on the same column.
    task automatic bounce(input logic [3:0] code);
        logic [1:0] r;
        logic [1:0] c;
        logic [3:0] target;
        logic [3:0] nxt;
        key_pos(code, r, c);
        target = ~(4'b0001 << c);
        nxt    = {target[2:0], target[3]};
        wait_col_start(c);
        key_col  = c;
        key_rows = ~(4'b0001 << r);
        key_down = 1'b1;
        repeat (7) @(negedge clock);
        key_down = 1'b0;
        @(negedge clock);
        check("bounce_same_col", COL, target);
        repeat (4) @(negedge clock);
        check("bounce_full_dwell", COL, nxt);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (key_valid) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_key_valid: got key_code %0d, expected no pulse at %0t",
                             key_code, $time);
                end else begin
                    e = sb_q.pop_front();
                    check("key_code", key_code, e.code);
                    @(negedge clock);
                    check("key_valid_width", key_valid, 0);
                    check("key_code_hold", key_code, e.code);
                    check("value", value, e.value);
                    check("ndigits", ndigits, e.nd);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        clear     = 1'b0;
        entry_clr = 1'b0;
        key_down  = 1'b0;
        key_rows  = 4'hF;
        key_col   = 2'd0;
        repeat (3) @(negedge clock);
        check("reset_COL", COL, 4'b1110);
        check("reset_key_valid", key_valid, 0);
        check("reset_key_code", key_code, 0);
        check("reset_value", value, 0);
        check("reset_ndigits", ndigits, 0);

        clear = 1'b1;
        for (int k = 0; k < 16; k++) begin
            check("scan_COL", COL, colseq[k / 4]);
            @(negedge clock);
        end

        for (int v = 0; v < NV; v++) begin
            if (vecs[v].bnc) begin
                bounce(vecs[v].code);
            end else begin
                press(vecs[v]);
            end
        end

        repeat (40) @(negedge clock);
        check("pending_expected", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_entry.md
KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 Parameter SCAN_DIV, default 1000, clock cycles each column is driven before advancing.
REQ-002 Parameter DEBOUNCE_CNT, default 20000, consecutive stable cycles required for press/release acceptance.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset; ports named as below.
REQ-004 clock  in  1  system clock, all logic on rising edge.
REQ-005 clear  in  1  synchronous active-low reset.
REQ-006 Rows  in  4  keypad row lines, active-low, pre-synchronised.
REQ-007 entry_clr  in  1  one-cycle pulse from control unit, zeroes the accumulated operand.
REQ-008 COL  out  4  column drive, exactly one bit low at all times.
REQ-009 key_valid  out  1  one-cycle pulse per accepted keypress.
REQ-010 key_code  out  4  code of last accepted key (0-9 digits, 10-15 per shared key table).
REQ-011 value  out  8  accumulated unsigned decimal operand, feeds AU operand bus and display mux.
REQ-012 ndigits  out  2  number of digits currently held (0-3).

Function
REQ-013 FSM states SCAN, PRESS_DB, HELD, RELEASE_DB; reset state SCAN.
REQ-014 SCAN: drive current column low SCAN_DIV cycles; sample Rows on last dwell cycle; all high -> rotate COL 1110->1101->1011->0111->1110; any low -> freeze column, go PRESS_DB.
REQ-015 Multiple rows low: lowest-index low row selects the key.
REQ-016 PRESS_DB: Rows must equal captured pattern DEBOUNCE_CNT consecutive cycles; any change -> SCAN, same column, dwell counter restarted.
REQ-017 On PRESS_DB completion: key_valid high exactly one cycle, key_code updated same cycle, go HELD.
REQ-018 HELD: no further key_valid while any row low; all rows high -> RELEASE_DB.
REQ-019 RELEASE_DB: all rows high DEBOUNCE_CNT consecutive cycles -> SCAN next column; any row low -> HELD.
REQ-020 Digit key (0-9): value <= value*10 + digit, ndigits+1, both visible cycle after key_valid.
REQ-021 Digit rejected (value, ndigits unchanged, key_valid still pulses) if ndigits==3 or value*10+digit > 255; intermediate arithmetic 12 bits wide.
REQ-022 Key code 13 (clear-entry): value<=0, ndigits<=0; other non-digit codes: no accumulator change.
REQ-023 entry_clr high: value<=0, ndigits<=0; coincident with digit acceptance, clear wins and the digit is discarded.
REQ-024 entry_clr SHALL NOT affect FSM state, COL, or key_code.

Reset
REQ-025 clear low at a clock edge: state SCAN, COL=4'b1110, counters 0, key_valid=0, key_code=0, value=0, ndigits=0; applies from any state, including mid-debounce.

Configuration
REQ-026 KEYPAD_BACKSPACE_EN defined: key code 14 performs value <= value/10, ndigits-1 (no change when ndigits==0).
REQ-027 KEYPAD_BACKSPACE_EN undefined: key code 14 changes no accumulator state; key_valid/key_code still reported.

Structure
REQ-028 Shared package calc_pkg holds key-code constants (KEY_CLR=13, KEY_BKSP=14), row/column-to-code table, FSM state enum, and operand width 8.
REQ-029 One sub-module, keypad_debounce (stable-count with restart on change), SHALL be instantiated for press and release debounce.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=8)
REQ-030 Release clear, no keys -> COL cycles 1110,1101,1011,0111 each 4 cycles, key_valid never high.
REQ-031 Enter digits 1,2,3 (clean presses) -> three key_valid pulses, value 1,12,123, ndigits 3; fourth digit 4 -> value stays 123.
REQ-032 Enter 2,5,6 -> third digit rejected, value 25, ndigits 2; then 5 -> value 255.
REQ-033 Row bounces low 3 cycles then high during PRESS_DB -> no key_valid, SCAN resumes same column; 20-cycle hold -> exactly one key_valid.
REQ-034 entry_clr coincident with digit 7 acceptance at value 4 -> value 0, ndigits 0, key_code 7.
REQ-035 clear asserted mid-HELD with value 42 -> next cycle all outputs at reset values; with macro on, keys 4,2,backspace -> value 4, ndigits 1.
